// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor: a table of 2-bit saturating counters read
// in fetch, trained by the decode-stage comparator outcome, with branch/mispredict stats.
module branch_predictor #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  output logic             predict_takenF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic [31:0]      pcD,
  input  logic             branchD,
  input  logic             actual_takenD,
  output logic             predict_takenD,
  output logic             mispredictD,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]       ctr_q [0:DEPTH-1];
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_d;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             update;
  logic             pred_q;
  logic             pred_d;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_d;

  // Word-offset and upper PC bits do not index the table (aliasing is intentional).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pcF[31:IDX_W+2], pcF[1:0], pcD[31:IDX_W+2], pcD[1:0]};

  assign rd_idx = pcF[IDX_W+1:2];
  assign wr_idx = pcD[IDX_W+1:2];
  assign update = branchD & ~stallD;

  // Reads see the registered table, so a same-cycle write is visible only next cycle.
  assign predict_takenF = ctr_q[rd_idx][1];
  assign predict_takenD = pred_q;
  assign mispredictD    = update & (pred_q != actual_takenD);
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

  always_comb begin
    ctr_cur = ctr_q[wr_idx];
    ctr_d   = ctr_cur;
    if (actual_takenD) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
    end
  end

  always_comb begin
    pred_d = pred_q;
    if (flushD)       pred_d = 1'b0;
    else if (!stallD) pred_d = predict_takenF;
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (update)      branch_cnt_d     = branch_cnt_q + CNT_W'(1);
    if (mispredictD) mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (update) begin
      ctr_q[wr_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_q           <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      pred_q           <= pred_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, saturation, stall/flush, aliasing,
// same-index collision and reset-over-update, with hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        predict_takenF;
  logic        stallD;
  logic        flushD;
  logic [31:0] pcD;
  logic        branchD;
  logic        actual_takenD;
  logic        predict_takenD;
  logic        mispredictD;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  branch_predictor #(.IDX_W(6), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcF            (pcF),
    .predict_takenF (predict_takenF),
    .stallD         (stallD),
    .flushD         (flushD),
    .pcD            (pcD),
    .branchD        (branchD),
    .actual_takenD  (actual_takenD),
    .predict_takenD (predict_takenD),
    .mispredictD    (mispredictD),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Look up the prediction for a PC without letting it reach the F->D register.
  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
    pcF = pc;
    #1;
    chk(tag, {31'd0, predict_takenF}, {31'd0, exp});
    pcF = 32'h0;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken);
    pcD = pc;
    branchD = 1'b1;
    actual_takenD = taken;
    tick();
    branchD = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] bc, input logic [31:0] mc);
    chk({tag, "_bc"}, branch_cnt, bc);
    chk({tag, "_mc"}, mispredict_cnt, mc);
  endtask

  initial begin
    rst = 1'b1; pcF = 32'h0; stallD = 1'b0; flushD = 1'b0;
    pcD = 32'h0; branchD = 1'b0; actual_takenD = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_predD", {31'd0, predict_takenD}, 32'd0);
    chk("rst_mispD", {31'd0, mispredictD}, 32'd0);
    chk_cnt("rst", 32'd0, 32'd0);
    for (int i = 0; i < 64; i++) begin
      pcF = 32'(i * 4);
      #1;
      chk("sweep_predF", {31'd0, predict_takenF}, 32'd0);
    end
    pcF = 32'h0;
    tick();

    // Training: pcF idles on entry 0 (01), so predD stays 0 and taken == mispredict.
    train(32'h0040_0010, 1'b1);
    chk_pred("train1_predF", 32'h0040_0010, 1'b1);
    chk_cnt("train1", 32'd1, 32'd1);
    train(32'h0040_0010, 1'b1);
    train(32'h0040_0010, 1'b1);
    train(32'h0040_0010, 1'b1);
    chk_pred("sat_hi_predF", 32'h0040_0010, 1'b1);
    train(32'h0040_0010, 1'b0);
    chk_pred("dec1_predF", 32'h0040_0010, 1'b1);
    train(32'h0040_0010, 1'b0);
    chk_pred("dec2_predF", 32'h0040_0010, 1'b0);
    chk_cnt("train6", 32'd6, 32'd4);

    // Mispredict from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pcF = 32'h0040_0020;
    tick();
    pcF = 32'h0;
    pcD = 32'h0040_0020; branchD = 1'b1; actual_takenD = 1'b1;
    #1;
    chk("misp_predD", {31'd0, predict_takenD}, 32'd0);
    chk("misp_flag", {31'd0, mispredictD}, 32'd1);
    tick();
    branchD = 1'b0;
    chk_cnt("misp", 32'd1, 32'd1);
    chk_pred("misp_trained", 32'h0040_0020, 1'b1);

    // Stall: table, predD and counters frozen; one evaluation on release.
    pcF = 32'h0040_0020;
    stallD = 1'b1;
    pcD = 32'h0040_0030; branchD = 1'b1; actual_takenD = 1'b1;
    #1;
    chk("stall_misp0", {31'd0, mispredictD}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_misp", {31'd0, mispredictD}, 32'd0);
      chk("stall_predD", {31'd0, predict_takenD}, 32'd0);
    end
    chk_cnt("stall", 32'd1, 32'd1);
    stallD = 1'b0;
    pcF = 32'h0;
    #1;
    chk("release_misp", {31'd0, mispredictD}, 32'd1);
    tick();
    branchD = 1'b0;
    chk_cnt("release", 32'd2, 32'd2);
    chk_pred("release_predF", 32'h0040_0030, 1'b1);
    train(32'h0040_0030, 1'b0);
    chk_pred("one_update", 32'h0040_0030, 1'b0);
    chk_cnt("one_update", 32'd3, 32'd2);

    // Flush beats stall.
    pcF = 32'h0040_0020;
    tick();
    chk("preflush_predD", {31'd0, predict_takenD}, 32'd1);
    flushD = 1'b1; stallD = 1'b1;
    tick();
    chk("flush_predD", {31'd0, predict_takenD}, 32'd0);
    flushD = 1'b0; stallD = 1'b0; pcF = 32'h0;
    tick();

    // Aliasing: 0x004 and 0x104 share index 1.
    train(32'h0000_0004, 1'b1);
    chk_pred("alias_predF", 32'h0000_0104, 1'b1);
    chk_cnt("alias", 32'd4, 32'd3);

    // Same-index read/write collision.
    pcF = 32'h0040_0040;
    pcD = 32'h0040_0040; branchD = 1'b1; actual_takenD = 1'b1;
    #1;
    chk("coll_old", {31'd0, predict_takenF}, 32'd0);
    tick();
    branchD = 1'b0;
    chk("coll_new", {31'd0, predict_takenF}, 32'd1);
    pcF = 32'h0;
    chk_cnt("coll", 32'd5, 32'd4);

    // Reset during an update cycle discards the update.
    pcD = 32'h0040_0040; branchD = 1'b1; actual_takenD = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; branchD = 1'b0;
    chk_pred("rstupd_predF", 32'h0040_0040, 1'b0);
    chk_cnt("rstupd", 32'd0, 32'd0);
    train(32'h0040_0040, 1'b1);
    chk_pred("rstupd_is01", 32'h0040_0040, 1'b1);
    chk_pred("rstupd_other", 32'h0040_0010, 1'b0);
    chk_cnt("rstupd_after", 32'd1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
